// File: rtl/dw_conv_tmux_if.sv
// Streaming handshake bundle for the depthwise-conv layer: input activation
// vectors in, requantised/clamped channel vector out.
interface dw_conv_tmux_if #(
    parameter int CHANNELS = 8,
    parameter int KERNEL   = 9,
    parameter int ACT_W    = 8
) ();
    logic                               in_valid;
    logic                               in_ready;
    logic [CHANNELS*KERNEL*ACT_W-1:0]   in_act;
    logic                               out_valid;
    logic                               out_ready;
    logic [CHANNELS*ACT_W-1:0]          out_act;

    modport slave (
        input  in_valid, in_act, out_ready,
        output in_ready, out_valid, out_act
    );

    modport master (
        output in_valid, in_act, out_ready,
        input  in_ready, out_valid, out_act
    );
endinterface

// File: rtl/dw_conv_tmux.sv
// Time-multiplexed depthwise convolution: LANES channels per beat run a KERNEL-tap
// MAC (stage 1), then bias add, arithmetic shift and ReLU clamp (stage 2).
module dw_conv_tmux #(
    parameter int CHANNELS  = 8,
    parameter int LANES     = 2,
    parameter int KERNEL    = 9,
    parameter int ACT_W     = 8,
    parameter int WGT_W     = 5,
    parameter int BIAS_W    = 8,
    parameter int ACC_W     = 32,
    parameter int SHIFT     = 3,
    parameter int CLAMP_MAX = 6
) (
    input  logic                                clk,
    input  logic                                rst,
    dw_conv_tmux_if.slave                       bus,
    input  logic                                wgt_we,
    input  logic [$clog2(CHANNELS*KERNEL)-1:0]  wgt_addr,
    input  logic [WGT_W-1:0]                    wgt_data,
    input  logic                                bias_we,
    input  logic [$clog2(CHANNELS)-1:0]         bias_addr,
    input  logic [BIAS_W-1:0]                   bias_data,
    output logic                                cfg_err
);
    localparam int BEATS  = CHANNELS / LANES;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int WA_W   = $clog2(CHANNELS*KERNEL);
    localparam int BA_W   = $clog2(CHANNELS);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        DRAIN   = 2'd2,
        HOLD    = 2'd3
    } state_e;

    state_e                             state_r, state_nxt_s;
    logic [BEAT_W-1:0]                  beat_r;
    logic                               accept_s, last_beat_s;
    logic                               wgt_ok_s, bias_ok_s;
    logic [CHANNELS*KERNEL*ACT_W-1:0]   act_r;
    logic signed [WGT_W-1:0]            wgt_r [CHANNELS*KERNEL];
    logic signed [BIAS_W-1:0]           bias_r [CHANNELS];
    logic signed [ACC_W-1:0]            acc_s [LANES];
    logic signed [ACC_W-1:0]            s1_acc_r [LANES];
    logic [BEAT_W-1:0]                  s1_grp_r;
    logic                               s1_valid_r, s1_last_r, s2_done_r;
    logic signed [ACC_W-1:0]            y_s [LANES];
    logic signed [ACC_W-1:0]            q_s [LANES];
    logic [ACT_W-1:0]                   res_s [LANES];
    logic                               out_valid_r, cfg_err_r;
    logic [CHANNELS*ACT_W-1:0]          out_act_r;

    function automatic int chan_idx(input logic [BEAT_W-1:0] grp, input int lane);
        return int'(grp) * LANES + lane;
    endfunction

    function automatic int tap_idx(input logic [BEAT_W-1:0] grp, input int lane, input int tap);
        return chan_idx(grp, lane) * KERNEL + tap;
    endfunction

    assign bus.in_ready  = (state_r == IDLE) && !rst;
    assign accept_s      = bus.in_valid && bus.in_ready;
    assign last_beat_s   = (beat_r == BEAT_W'(BEATS - 1));
    // Config writes only land while idle, so an in-flight vector never sees a partial update.
    assign wgt_ok_s      = (state_r == IDLE) && (32'(wgt_addr) < 32'(CHANNELS*KERNEL));
    assign bias_ok_s     = (state_r == IDLE) && (32'(bias_addr) < 32'(CHANNELS));
    assign bus.out_valid = out_valid_r;
    assign bus.out_act   = out_act_r;
    assign cfg_err       = cfg_err_r;

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state_r <= IDLE;
        else     state_r <= state_nxt_s;
    end

    // FSM next-state; DRAIN waits until stage 2 has retired the last group
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE:    if (accept_s)      state_nxt_s = COMPUTE; else state_nxt_s = IDLE;
            COMPUTE: if (last_beat_s)   state_nxt_s = DRAIN;   else state_nxt_s = COMPUTE;
            DRAIN:   if (s2_done_r)     state_nxt_s = HOLD;    else state_nxt_s = DRAIN;
            HOLD:    if (bus.out_ready) state_nxt_s = IDLE;    else state_nxt_s = HOLD;
            default:                    state_nxt_s = IDLE;
        endcase
    end

    // Beat counter and input vector latch
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_r <= '0;
            act_r  <= '0;
        end else if (accept_s) begin
            beat_r <= '0;
            act_r  <= bus.in_act;
        end else if (state_r == COMPUTE) begin
            beat_r <= beat_r + BEAT_W'(1);
        end else begin
            beat_r <= beat_r;
        end
    end

    // Weight and bias storage with range/state-gated writes
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS*KERNEL; i++) wgt_r[i] <= '0;
            for (int i = 0; i < CHANNELS; i++)        bias_r[i] <= '0;
            cfg_err_r <= 1'b0;
        end else begin
            if (wgt_we && wgt_ok_s)   wgt_r[wgt_addr]   <= wgt_data;
            if (bias_we && bias_ok_s) bias_r[bias_addr] <= bias_data;
            cfg_err_r <= (wgt_we && !wgt_ok_s) || (bias_we && !bias_ok_s);
        end
    end

    // Stage 1 combinational MAC over the current group of channels
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            acc_s[l] = '0;
            for (int k = 0; k < KERNEL; k++) begin
                acc_s[l] = acc_s[l]
                         + ACC_W'(wgt_r[WA_W'(tap_idx(beat_r, l, k))])
                         * ACC_W'($signed(act_r[tap_idx(beat_r, l, k)*ACT_W +: ACT_W]));
            end
        end
    end

    // Stage 1 register
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_last_r  <= 1'b0;
            s1_grp_r   <= '0;
            for (int l = 0; l < LANES; l++) s1_acc_r[l] <= '0;
        end else begin
            s1_valid_r <= (state_r == COMPUTE);
            s1_last_r  <= last_beat_s;
            s1_grp_r   <= beat_r;
            s1_acc_r   <= acc_s;
        end
    end

    // Stage 2 combinational bias add, requant shift and ReLU clamp
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            y_s[l] = s1_acc_r[l] + ACC_W'(bias_r[BA_W'(chan_idx(s1_grp_r, l))]);
            q_s[l] = y_s[l] >>> SHIFT;
            if (y_s[l][ACC_W-1])                  res_s[l] = '0;
            else if (q_s[l] > ACC_W'(CLAMP_MAX))  res_s[l] = ACT_W'(CLAMP_MAX);
            else                                  res_s[l] = q_s[l][ACT_W-1:0];
        end
    end

    // Stage 2 register: write finished group into its output slices
    always_ff @(posedge clk) begin
        if (rst) begin
            out_act_r <= '0;
            s2_done_r <= 1'b0;
        end else begin
            s2_done_r <= s1_valid_r && s1_last_r;
            if (s1_valid_r) begin
                for (int l = 0; l < LANES; l++)
                    out_act_r[chan_idx(s1_grp_r, l)*ACT_W +: ACT_W] <= res_s[l];
            end
        end
    end

    // Output valid tracks the HOLD state one-for-one
    always_ff @(posedge clk) begin
        if (rst) out_valid_r <= 1'b0;
        else     out_valid_r <= (state_nxt_s == HOLD);
    end
endmodule

// File: tb/tb_dw_conv_tmux.sv
// Self-checking bench for dw_conv_tmux: directed scenarios plus randomised vectors
// compared against an integer-arithmetic reference of the layer.
module tb_dw_conv_tmux;
    localparam int CH   = 8;
    localparam int KER  = 9;
    localparam int AW   = 8;
    localparam int NTAP = CH*KER;
    localparam int LAT  = 6;

    logic clk = 1'b0;
    logic rst;
    logic wgt_we, bias_we;
    logic [6:0] wgt_addr;
    logic [4:0] wgt_data;
    logic [2:0] bias_addr;
    logic [7:0] bias_data;
    logic cfg_err;

    int checks = 0;
    int errors = 0;
    int w_m [NTAP];
    int b_m [CH];

    dw_conv_tmux_if #(.CHANNELS(CH), .KERNEL(KER), .ACT_W(AW)) bus ();

    dw_conv_tmux dut (
        .clk(clk), .rst(rst), .bus(bus),
        .wgt_we(wgt_we), .wgt_addr(wgt_addr), .wgt_data(wgt_data),
        .bias_we(bias_we), .bias_addr(bias_addr), .bias_data(bias_data),
        .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: y = sum(w*a) + b; negative -> 0, else floor(y/8) limited to 6.
    function automatic logic [CH*AW-1:0] model_out(input logic [NTAP*AW-1:0] acts);
        logic [CH*AW-1:0] r;
        int sum, v;
        r = '0;
        for (int c = 0; c < CH; c++) begin
            sum = b_m[c];
            for (int k = 0; k < KER; k++)
                sum += w_m[c*KER+k] * int'($signed(acts[(c*KER+k)*AW +: AW]));
            if (sum < 0) v = 0;
            else         v = sum / 8;
            if (v > 6) v = 6;
            r[c*AW +: AW] = 8'(v);
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_wgt(input int a, input int d);
        wgt_we = 1'b1; wgt_addr = 7'(a); wgt_data = 5'(d);
        tick();
        wgt_we = 1'b0;
    endtask

    task automatic wr_bias(input int a, input int d);
        bias_we = 1'b1; bias_addr = 3'(a); bias_data = 8'(d);
        tick();
        bias_we = 1'b0;
    endtask

    task automatic load_all(input int wv, input int bv);
        for (int i = 0; i < NTAP; i++) begin wr_wgt(i, wv); w_m[i] = wv; end
        for (int i = 0; i < CH; i++)   begin wr_bias(i, bv); b_m[i] = bv; end
    endtask

    function automatic logic [NTAP*AW-1:0] fill_acts(input int v);
        logic [NTAP*AW-1:0] a;
        for (int i = 0; i < NTAP; i++) a[i*AW +: AW] = 8'(v);
        return a;
    endfunction

    function automatic logic [NTAP*AW-1:0] rand_acts();
        logic [NTAP*AW-1:0] a;
        for (int i = 0; i < NTAP; i++) a[i*AW +: AW] = 8'(int'($urandom_range(0, 12)) - 6);
        return a;
    endfunction

    // Offer a vector, then count edges from the accept edge to out_valid (99 = timeout).
    task automatic send_vec(input logic [NTAP*AW-1:0] acts, output int lat, output logic [CH*AW-1:0] res);
        lat = 99;
        res = '0;
        bus.in_act = acts;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 20 && !bus.in_ready; i++) tick();
        if (!bus.in_ready) begin
            bus.in_valid = 1'b0;
            return;
        end
        tick();
        bus.in_valid = 1'b0;
        wgt_we = 1'b0;
        bias_we = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (bus.out_valid) begin
                lat = i;
                res = bus.out_act;
                break;
            end
        end
    endtask

    task automatic release_out();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++; if (bus.in_ready !== 1'b0)  begin errors++; $display("FAIL reset_in_ready: got %b expected 0", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
        checks++; if (cfg_err !== 1'b0)       begin errors++; $display("FAIL reset_cfg_err: got %b expected 0", cfg_err); end
        checks++; if (bus.out_act !== 64'h0)  begin errors++; $display("FAIL reset_out_act: got %h expected 0", bus.out_act); end
        rst = 1'b0;
        #1;
        checks++; if (bus.in_ready !== 1'b1)  begin errors++; $display("FAIL idle_in_ready: got %b expected 1", bus.in_ready); end
        for (int i = 0; i < NTAP; i++) w_m[i] = 0;
        for (int i = 0; i < CH; i++)   b_m[i] = 0;
    endtask

    task automatic test_basic();
        int lat; logic [CH*AW-1:0] res, exp_v;
        load_all(1, 0);
        send_vec(fill_acts(1), lat, res);
        exp_v = {8{8'd1}};
        checks++; if (lat !== LAT)             begin errors++; $display("FAIL basic_latency: got %0d expected %0d", lat, LAT); end
        checks++; if (res !== exp_v)           begin errors++; $display("FAIL basic_out: got %h expected %h", res, exp_v); end
        checks++; if (res !== model_out(fill_acts(1))) begin errors++; $display("FAIL basic_model: got %h expected %h", res, model_out(fill_acts(1))); end
        release_out();
        checks++; if (bus.out_valid !== 1'b0)  begin errors++; $display("FAIL basic_release: got %b expected 0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b1)   begin errors++; $display("FAIL basic_idle: got %b expected 1", bus.in_ready); end
    endtask

    task automatic test_clamp();
        int lat; logic [CH*AW-1:0] res, exp_v;
        send_vec(fill_acts(8), lat, res);
        exp_v = {8{8'd6}};
        checks++; if (res !== exp_v) begin errors++; $display("FAIL clamp_out: got %h expected %h", res, exp_v); end
        release_out();
    endtask

    task automatic test_negative();
        int lat; logic [CH*AW-1:0] res, exp_v;
        for (int i = 0; i < CH; i++) begin wr_bias(i, 4); b_m[i] = 4; end
        send_vec(fill_acts(-1), lat, res);
        exp_v = '0;
        checks++; if (res !== exp_v) begin errors++; $display("FAIL neg_zero: got %h expected %h", res, exp_v); end
        release_out();
        wr_bias(0, 100); b_m[0] = 100;
        send_vec(fill_acts(-1), lat, res);
        exp_v = {56'h0, 8'd6};
        checks++; if (res !== exp_v) begin errors++; $display("FAIL neg_ch0_clamp: got %h expected %h", res, exp_v); end
        checks++; if (res !== model_out(fill_acts(-1))) begin errors++; $display("FAIL neg_model: got %h expected %h", res, model_out(fill_acts(-1))); end
        release_out();
    endtask

    task automatic test_backpressure();
        int lat; logic [CH*AW-1:0] res; logic [NTAP*AW-1:0] a;
        a = rand_acts();
        send_vec(a, lat, res);
        checks++; if (res !== model_out(a)) begin errors++; $display("FAIL bp_out: got %h expected %h", res, model_out(a)); end
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_act !== res || bus.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold: cycle %0d valid %b act %h ready %b expected 1 %h 0", i, bus.out_valid, bus.out_act, bus.in_ready, res);
            end
        end
        release_out();
        checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_release: valid %b ready %b expected 0 1", bus.out_valid, bus.in_ready); end
    endtask

    task automatic test_cfg_err();
        int lat; logic [CH*AW-1:0] res; logic [NTAP*AW-1:0] a;
        a = rand_acts();
        bus.in_act = a; bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        wgt_we = 1'b1; wgt_addr = 7'd0; wgt_data = 5'(w_m[0] + 3);
        tick();
        wgt_we = 1'b0;
        checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL cfg_busy_err: got %b expected 1", cfg_err); end
        tick();
        checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL cfg_pulse: got %b expected 0", cfg_err); end
        lat = 99;
        for (int i = 0; i < 20; i++) begin
            if (bus.out_valid) begin lat = i; break; end
            tick();
        end
        checks++; if (lat == 99 || bus.out_act !== model_out(a)) begin errors++; $display("FAIL cfg_busy_vec: got %h expected %h", bus.out_act, model_out(a)); end
        release_out();
        wgt_we = 1'b1; wgt_addr = 7'd72; wgt_data = 5'd9;
        tick();
        wgt_we = 1'b0;
        checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL cfg_range_err: got %b expected 1", cfg_err); end
        a = rand_acts();
        send_vec(a, lat, res);
        checks++; if (res !== model_out(a)) begin errors++; $display("FAIL cfg_unchanged: got %h expected %h", res, model_out(a)); end
        release_out();
    endtask

    task automatic test_random();
        int lat, n, d; logic [CH*AW-1:0] res; logic [NTAP*AW-1:0] a;
        for (int it = 0; it < 25; it++) begin
            n = int'($urandom_range(0, 6));
            for (int j = 0; j < n; j++) begin
                int ad;
                ad = int'($urandom_range(0, NTAP-1)); d = int'($urandom_range(0, 6)) - 3;
                wr_wgt(ad, d); w_m[ad] = d;
            end
            if ($urandom_range(0, 1) == 1) begin
                int bd;
                bd = int'($urandom_range(0, CH-1)); d = int'($urandom_range(0, 40)) - 20;
                wr_bias(bd, d); b_m[bd] = d;
            end
            if ($urandom_range(0, 1) == 1) begin
                int ad;
                ad = int'($urandom_range(0, NTAP-1)); d = int'($urandom_range(0, 6)) - 3;
                wgt_we = 1'b1; wgt_addr = 7'(ad); wgt_data = 5'(d); w_m[ad] = d;
            end
            bus.out_ready = ($urandom_range(0, 1) == 1);
            a = rand_acts();
            send_vec(a, lat, res);
            checks++; if (lat !== LAT)         begin errors++; $display("FAIL rand_latency: iter %0d got %0d expected %0d", it, lat, LAT); end
            checks++; if (res !== model_out(a)) begin errors++; $display("FAIL rand_out: iter %0d got %h expected %h", it, res, model_out(a)); end
            release_out();
        end
    endtask

    task automatic test_rst_abort();
        int lat, seen; logic [CH*AW-1:0] res, exp_v;
        bus.in_act = rand_acts(); bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
        checks++; if (bus.out_valid !== 1'b0 || bus.out_act !== 64'h0 || bus.in_ready !== 1'b0) begin errors++; $display("FAIL abort_state: valid %b act %h ready %b expected 0 0 0", bus.out_valid, bus.out_act, bus.in_ready); end
        rst = 1'b0;
        for (int i = 0; i < NTAP; i++) w_m[i] = 0;
        for (int i = 0; i < CH; i++)   b_m[i] = 0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin tick(); if (bus.out_valid) seen++; end
        checks++; if (seen != 0) begin errors++; $display("FAIL abort_no_output: got %0d valid cycles expected 0", seen); end
        send_vec(fill_acts(5), lat, res);
        exp_v = '0;
        checks++; if (lat !== LAT || res !== exp_v) begin errors++; $display("FAIL abort_weights_zero: lat %0d got %h expected %0d %h", lat, res, LAT, exp_v); end
        release_out();
    endtask

    initial begin
        rst = 1'b1;
        wgt_we = 1'b0; wgt_addr = '0; wgt_data = '0;
        bias_we = 1'b0; bias_addr = '0; bias_data = '0;
        bus.in_valid = 1'b0; bus.in_act = '0; bus.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_clamp();
        test_negative();
        test_backpressure();
        test_cfg_err();
        test_random();
        test_rst_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
